// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave shift engine.
`timescale 1ns/1ps
package spi_slave_pkg;

    typedef enum logic {
        IDLE,
        ACTIVE
    } spi_slv_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/spi_slave_sync_edge.sv
// Two-flop synchronizer plus an edge flop; reports level, rise and fall of an async pin.
`timescale 1ns/1ps
module spi_slave_sync_edge
    import spi_slave_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            edge_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = level_o & ~edge_q;
    assign fall_o  = ~level_o & edge_q;

endmodule

// File: rtl/spi_slave_shift_engine.sv
// SPI slave serial engine, all CPOL/CPHA modes, MSB/LSB first, oversampled on pclk.
// Optional feature: define SPI_SLAVE_OVERRUN_DET_EN to add the sticky rx_overrun flag.
`timescale 1ns/1ps
module spi_slave_shift_engine
    import spi_slave_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic                  sclk,
    input  logic                  cs_n,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  tx_underrun,
    output logic                  abort,
`ifdef SPI_SLAVE_OVERRUN_DET_EN
    output logic                  rx_overrun,
`endif
    output logic                  busy
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    spi_mode_t              mode;
    spi_slv_state_e         state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0]  txsh_q, rxsh_q, txbuf_q, rx_data_q, load_word, rx_shift_d;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   txfull_q, rx_valid_q, miso_q, miso_oe_q, abort_q, underrun_q;
    logic                   sclk_lvl, sclk_rise, sclk_fall, cs_lvl, cs_rise, cs_fall;
    logic                   sclk_edge, lead, trail, sample_edge, shift_edge;
    logic                   complete, load, push, pop, keep_old, mosi_s;

    assign mode = '{cpol: cpol, cpha: cpha};

    spi_slave_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
        .clk_i(pclk), .rst_ni(areset), .d_i(sclk),
        .level_o(sclk_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );

    spi_slave_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk_i(pclk), .rst_ni(areset), .d_i(cs_n),
        .level_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) mosi_q <= '0;
        else         mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // sclk edges only count while the synchronized select is low
    assign sclk_edge   = ~cs_lvl & (sclk_rise | sclk_fall);
    assign lead        = sclk_edge & (sclk_lvl != mode.cpol);
    assign trail       = sclk_edge & (sclk_lvl == mode.cpol);
    assign sample_edge = mode.cpha ? trail : lead;
    assign shift_edge  = mode.cpha ? lead : trail;

    assign complete   = (state_q == ACTIVE) & ~cs_rise & sample_edge &
                        (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign load       = ((state_q == IDLE) & cs_fall) | complete;
    assign load_word  = txfull_q ? txbuf_q : IDLE_WORD;
    assign push       = tx_valid & ~txfull_q;
    assign pop        = rx_valid_q & rx_ready;
    assign rx_shift_d = lsb_first ? {mosi_s, rxsh_q[DATA_WIDTH-1:1]}
                                  : {rxsh_q[DATA_WIDTH-2:0], mosi_s};

`ifdef SPI_SLAVE_OVERRUN_DET_EN
    logic rx_overrun_q;
    assign keep_old   = rx_valid_q & ~rx_ready;
    assign rx_overrun = rx_overrun_q;
`else
    assign keep_old = 1'b0;
`endif

    // A push coinciding with a load from an empty buffer stays in the buffer
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            txbuf_q  <= '0;
            txfull_q <= 1'b0;
        end else begin
            if (push) txbuf_q <= tx_data;
            txfull_q <= load ? push : (txfull_q | push);
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            miso_q     <= 1'b0;
            miso_oe_q  <= 1'b0;
            abort_q    <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            abort_q    <= 1'b0;
            underrun_q <= load & ~txfull_q;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= ACTIVE;
                        cnt_q     <= '0;
                        miso_oe_q <= 1'b1;
                        // cpha=0 presents the first bit immediately; cpha=1 waits for the leading edge
                        txsh_q    <= mode.cpha ? load_word : advance(load_word, lsb_first);
                        miso_q    <= mode.cpha ? 1'b0 : head_bit(load_word, lsb_first);
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        abort_q   <= (cnt_q != '0);
                        cnt_q     <= '0;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rxsh_q <= rx_shift_d;
                            if (complete) begin
                                cnt_q  <= '0;
                                txsh_q <= load_word;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        if (shift_edge) begin
                            miso_q <= head_bit(txsh_q, lsb_first);
                            txsh_q <= advance(txsh_q, lsb_first);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
            rx_overrun_q <= 1'b0;
`endif
        end else begin
            if (complete) begin
                rx_valid_q <= 1'b1;
                if (!keep_old) rx_data_q <= rx_shift_d;
            end else if (pop) begin
                rx_valid_q <= 1'b0;
            end
`ifdef SPI_SLAVE_OVERRUN_DET_EN
            rx_overrun_q <= rx_overrun_q | (complete & keep_old);
`endif
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = ~txfull_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign abort       = abort_q;
    assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Directed bench for spi_slave_shift_engine acting as the SPI master with hand-computed words.
`timescale 1ns/1ps
module tb_spi_slave_shift_engine;

    localparam int HP = 80;

    logic       pclk = 1'b0;
    logic       areset = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0;
    logic       sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, rx_ready = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, abort, busy;
    logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_DET_EN
    logic       rx_overrun;
`endif

    int checks = 0;
    int errors = 0;
    int abort_cnt = 0;
    int unr_cnt = 0;

    spi_slave_shift_engine #(.DATA_WIDTH(8), .IDLE_WORD(8'h00)) dut (
        .pclk(pclk), .areset(areset), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
        .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_underrun(tx_underrun), .abort(abort),
`ifdef SPI_SLAVE_OVERRUN_DET_EN
        .rx_overrun(rx_overrun),
`endif
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) begin
        if (abort) abort_cnt++;
        if (tx_underrun) unr_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check_eq({pfx, "_miso"}, miso, 0);
        check_eq({pfx, "_miso_oe"}, miso_oe, 0);
        check_eq({pfx, "_tx_ready"}, tx_ready, 1);
        check_eq({pfx, "_rx_valid"}, rx_valid, 0);
        check_eq({pfx, "_rx_data"}, rx_data, 0);
        check_eq({pfx, "_tx_underrun"}, tx_underrun, 0);
        check_eq({pfx, "_abort"}, abort, 0);
        check_eq({pfx, "_busy"}, busy, 0);
`ifdef SPI_SLAVE_OVERRUN_DET_EN
        check_eq({pfx, "_rx_overrun"}, rx_overrun, 0);
`endif
    endtask

    task automatic set_mode(input logic pol, input logic pha, input logic lsb);
        @(negedge pclk);
        cpol = pol; cpha = pha; lsb_first = lsb; sclk = pol;
        repeat (6) @(negedge pclk);
    endtask

    task automatic push_tx(input logic [7:0] d);
        @(negedge pclk);
        check_eq("tx_ready_before_push", tx_ready, 1);
        tx_data = d; tx_valid = 1'b1;
        @(negedge pclk);
        tx_valid = 1'b0;
        check_eq("tx_ready_after_push", tx_ready, 0);
    endtask

    task automatic pop_rx();
        @(negedge pclk);
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
    endtask

    task automatic select();
        @(negedge pclk);
        cs_n = 1'b0;
        repeat (8) @(negedge pclk);
    endtask

    task automatic deselect();
        #(HP);
        cs_n = 1'b1;
        repeat (8) @(negedge pclk);
    endtask

    // Master side: drives mosi and records miso in bit order received (first bit ends at [7])
    task automatic xfer(input logic [7:0] mo, input int nb, output logic [7:0] mi);
        logic b;
        mi = 8'h00;
        for (int i = 0; i < nb; i++) begin
            b = lsb_first ? mo[i] : mo[7-i];
            if (!cpha) begin
                mosi = b;
                #(HP);
                sclk = ~cpol;
                mi = {mi[6:0], miso};
                #(HP);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = b;
                #(HP);
                sclk = cpol;
                mi = {mi[6:0], miso};
                #(HP);
            end
        end
    endtask

    initial begin
        logic [7:0] mi, mi0, mi1;
        int ub, ab;

        repeat (3) @(negedge pclk);
        check_reset("rst");
        areset = 1'b1;
        repeat (4) @(negedge pclk);

        // Mode 0, MSB first
        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'hA5);
        ub = unr_cnt; ab = abort_cnt;
        select();
        check_eq("m0_busy", busy, 1);
        check_eq("m0_miso_oe", miso_oe, 1);
        check_eq("m0_no_underrun_at_load", unr_cnt - ub, 0);
        check_eq("m0_tx_ready_after_load", tx_ready, 1);
        xfer(8'h3C, 8, mi);
        deselect();
        check_eq("m0_miso_bits", mi, 8'hA5);
        check_eq("m0_rx_data", rx_data, 8'h3C);
        check_eq("m0_rx_valid", rx_valid, 1);
        check_eq("m0_no_abort", abort_cnt - ab, 0);
        check_eq("m0_busy_after", busy, 0);
        check_eq("m0_miso_oe_after", miso_oe, 0);
        check_eq("m0_miso_after", miso, 0);
        pop_rx();
        check_eq("m0_rx_valid_popped", rx_valid, 0);

        // Modes 1..3, LSB first
        for (int m = 1; m < 4; m++) begin
            set_mode(m[1], m[0], 1'b1);
            push_tx(8'h81);
            select();
            xfer(8'h0F, 8, mi);
            deselect();
            check_eq($sformatf("mode%0d_miso_bits", m), mi, 8'h81);
            check_eq($sformatf("mode%0d_rx_data", m), rx_data, 8'h0F);
            check_eq($sformatf("mode%0d_rx_valid", m), rx_valid, 1);
            pop_rx();
        end

        // Two words in one frame, one tx word pushed
        set_mode(1'b0, 1'b0, 1'b0);
        push_tx(8'h5A);
        ub = unr_cnt;
        select();
        xfer(8'h11, 8, mi0);
        check_eq("two_rx_first", rx_data, 8'h11);
        check_eq("two_underrun_once", unr_cnt - ub, 1);
        pop_rx();
        xfer(8'h22, 8, mi1);
        deselect();
        check_eq("two_miso_first", mi0, 8'h5A);
        check_eq("two_miso_second", mi1, 8'h00);
        check_eq("two_rx_second", rx_data, 8'h22);
        check_eq("two_rx_valid", rx_valid, 1);
        pop_rx();

        // Abort after 5 bits, then a normal frame
        ab = abort_cnt;
        select();
        xfer(8'hFF, 5, mi);
        deselect();
        check_eq("abort_pulse", abort_cnt - ab, 1);
        check_eq("abort_rx_valid", rx_valid, 0);
        check_eq("abort_busy", busy, 0);
        push_tx(8'hC3);
        select();
        xfer(8'h96, 8, mi);
        deselect();
        check_eq("post_abort_miso", mi, 8'hC3);
        check_eq("post_abort_rx", rx_data, 8'h96);
        check_eq("post_abort_valid", rx_valid, 1);
        check_eq("post_abort_no_new_abort", abort_cnt - ab, 1);
        pop_rx();

        // Two completed words with rx_ready held low
`ifdef SPI_SLAVE_OVERRUN_DET_EN
        check_eq("ovr_clear_before", rx_overrun, 0);
`endif
        select();
        xfer(8'h12, 8, mi);
        xfer(8'h34, 8, mi);
        deselect();
        check_eq("ovr_rx_valid", rx_valid, 1);
`ifdef SPI_SLAVE_OVERRUN_DET_EN
        check_eq("ovr_flag", rx_overrun, 1);
        check_eq("ovr_rx_keeps_first", rx_data, 8'h12);
`else
        check_eq("ovr_rx_second", rx_data, 8'h34);
`endif

        // Reset in the middle of a word
        push_tx(8'h77);
        select();
        xfer(8'hF0, 4, mi);
        check_eq("midrst_busy_before", busy, 1);
        areset = 1'b0;
        #1;
        check_reset("midrst");
        cs_n = 1'b1; sclk = cpol; mosi = 1'b0;
        repeat (3) @(negedge pclk);
        areset = 1'b1;
        repeat (6) @(negedge pclk);
        push_tx(8'hE7);
        select();
        xfer(8'h5B, 8, mi);
        deselect();
        check_eq("after_rst_miso", mi, 8'hE7);
        check_eq("after_rst_rx", rx_data, 8'h5B);
        check_eq("after_rst_valid", rx_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_shift_engine.md
# spi_slave_shift_engine

Synthesizable SPI slave serial engine that samples the bus driven by the master driver BFM: it captures `mosi` and returns data on `miso` for all four CPOL/CPHA modes, MSB- or LSB-first. It sits directly downstream of the master driver on the SPI interface signals. On the parallel side it exposes a one-entry transmit buffer with a valid/ready handshake and a one-entry receive holding register. `sclk`, `cs_n` and `mosi` are oversampled on the system clock; `pclk` must run at least 4x `sclk`.

## Interface
- DATA_WIDTH, 8, bits per SPI word (2..32)
- IDLE_WORD, '0, word shifted out when the transmit buffer is empty at word start
- pclk  in  1  system clock, all state on rising edge
- areset  in  1  asynchronous, active-low reset
- cpol  in  1  clock polarity; static while cs_n low
- cpha  in  1  clock phase; static while cs_n low
- lsb_first  in  1  1 = LSB first, 0 = MSB first; static while cs_n low
- sclk  in  1  SPI clock, asynchronous
- cs_n  in  1  active-low chip select, asynchronous
- mosi  in  1  master-out data, asynchronous
- miso  out  1  slave-out data
- miso_oe  out  1  miso output enable, high while selected
- tx_data  in  DATA_WIDTH  word to return to the master
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  transmit buffer empty
- rx_data  out  DATA_WIDTH  last received word
- rx_valid  out  1  rx_data holds an unread word
- rx_ready  in  1  consumer accepts rx_data
- tx_underrun  out  1  one-cycle pulse: IDLE_WORD was loaded
- abort  out  1  one-cycle pulse: cs_n rose mid-word
- busy  out  1  state is ACTIVE

## Operation
- Reset values: `miso`=0, `miso_oe`=0, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `tx_underrun`=0, `abort`=0, `busy`=0. The FSM is in IDLE and the bit counter is 0.
- Synchronization:
  - `sclk`, `cs_n` and `mosi` each pass through 2 flops.
  - A third flop on `sclk` and `cs_n` provides edge detection.
  - The leading edge is the transition away from `cpol`; the trailing edge is the return to `cpol`.
- Sample edge and shift edge:
  - cpha=0: sample on the leading edge, shift on the trailing edge.
  - cpha=1: shift on the leading edge, sample on the trailing edge.
- FSM states: IDLE and ACTIVE.
  - IDLE -> ACTIVE on a synchronized `cs_n` fall. The tx shift register loads from the buffer, or from IDLE_WORD with a `tx_underrun` pulse if the buffer is empty. The bit counter is set to 0 and `miso_oe` goes to 1.
  - cpha=0: the first bit is driven on `miso` at load. cpha=1: the first bit is driven at the first shift edge.
  - ACTIVE, sample edge: the synchronized `mosi` enters the rx shift register and the counter increments.
  - ACTIVE, counter reaches DATA_WIDTH:
    - The word moves to the holding register and `rx_valid` is set.
    - The counter returns to 0.
    - The tx shift register reloads from the buffer or IDLE_WORD, which supports back-to-back words within one cs frame.
  - ACTIVE -> IDLE on a synchronized `cs_n` rise.
    - If the counter is not 0: pulse `abort` and discard the partial word.
    - `miso_oe` goes to 0 and `miso` goes to 0.
- Bit order: `lsb_first` selects the shift direction of both shift registers.
- Handshakes:
  - TX is accepted when `tx_valid && tx_ready`. `tx_ready` falls the next cycle and rises again in the cycle after the buffer is loaded into the shift register.
  - RX is consumed when `rx_valid && rx_ready`, which clears `rx_valid` the next cycle.
- Simultaneous events:
  - Word completion and an rx pop in the same cycle: the new word wins and `rx_valid` stays 1.
  - A tx push and a shift-register load in the same cycle: the load takes the old buffer content if the buffer was full. Otherwise it takes IDLE_WORD, and the pushed word stays in the buffer.
- Reset while ACTIVE forces all reset values immediately.

## Timing
- The synchronized `cs_n` edge acts 3 `pclk` cycles after the pin edge. The same 3-cycle delay applies to `sclk` edges.
- `rx_valid` rises 1 cycle after the final sample edge is detected.
- `miso` updates 1 cycle after shift-edge detection. This requires `pclk` ≥ 4x `sclk` so that `miso` is stable before the master samples it.
- `abort` and `tx_underrun` are single-cycle pulses.

## Configuration
- `SPI_SLAVE_OVERRUN_DET_EN`
  - Defined: adds output `rx_overrun` (1 bit, reset 0). It is a sticky flag, set when a word completes while `rx_valid`=1 and not being popped in that cycle. In that case the new word is dropped and the holding register keeps the old word. The flag is cleared only by reset.
  - Undefined: no port; a completed word always overwrites the holding register.

## Structure
- Shared package `spi_slave_pkg` holds:
  - the state enum `spi_slv_state_e {IDLE, ACTIVE}`,
  - the mode typedef `spi_mode_t` (cpol and cpha),
  - the constant `SYNC_STAGES = 2`.
- Sub-module `spi_slave_sync_edge` is instantiated for `sclk` and `cs_n`. It contains the 2-flop synchronizer plus the edge flop, and outputs the level, rise and fall.

## Test plan
- Mode 0, MSB first, tx_data=8'hA5 pushed before `cs_n` fall; master sends 8'h3C -> `miso` bits 1,0,1,0,0,1,0,1; rx_data=8'h3C with `rx_valid`=1; no `abort`.
- Modes 1, 2 and 3 with `lsb_first`=1, tx 8'h81, master sends 8'h0F -> `miso` bits 1,0,0,0,0,0,0,1; rx_data=8'h0F in each mode.
- Two words in one cs frame with only one tx word pushed -> second word shifts out IDLE_WORD=8'h00; `tx_underrun` pulses once; both rx words are received in order.
- `cs_n` rises after 5 sclk cycles -> `abort` pulses for 1 cycle; `rx_valid` stays 0; the next full frame works normally.
- `rx_ready`=0 across two completed words:
  - with `SPI_SLAVE_OVERRUN_DET_EN` defined: `rx_overrun`=1 and rx_data keeps the first word;
  - without the macro: rx_data is the second word.
- Reset asserted mid-word (bit 4) -> all outputs go to their reset values the same cycle; a fresh frame after release completes correctly.
